mod_exp_ctrl: RTL and testbench
===============================

MOD_EXP_CTRL -- requirements
Module: mod_exp_ctrl

Interface
REQ-001 SHALL have ports: clk in 1 (clock); resetn in 1 (synchronous, active-low reset).
REQ-002 SHALL have ports: start in 1 (begin exponentiation); busy out 1; done out 1 (one-cycle completion pulse).
REQ-003 SHALL have operand ports, all 512-bit inputs: in_x (base, < in_m); in_e (exponent); in_m (odd modulus); in_r (R mod m, R=2^512); in_r2 (R^2 mod m).
REQ-004 SHALL have port in_elen, 10-bit input: exponent bit length, 1..512; value 0 means 512.
REQ-005 SHALL have port result, 512-bit output: x^e mod m.
REQ-006 SHALL have Montgomery-multiplier ports: mont_resetn out 1; mont_start out 1; mont_a, mont_b, mont_m out 512 each; mont_result in 514; mont_done in 1 (level; stays high until mont_resetn asserted).

Function
REQ-007 SHALL latch in_x, in_e, in_m, in_r, in_r2 and in_elen in IDLE when start=1, and assert busy from the next cycle until done.
REQ-008 SHALL ignore start while busy=1.
REQ-009 SHALL compute left-to-right binary exponentiation: xt=mont(x,R2); A=R mod m; for i=elen-1 down to 0 {A=mont(A,A); if e[i] A=mont(A,xt)}; result=mont(A,1).
REQ-010 SHALL run every Montgomery op as ISSUE -> WAIT -> CAPTURE.
REQ-011 ISSUE SHALL be 1 cycle: mont_start=1 with mont_a/mont_b/mont_m stable.
REQ-012 WAIT SHALL hold until mont_done=1, with mont_a/mont_b/mont_m held constant.
REQ-013 CAPTURE SHALL be 1 cycle: latch mont_result[511:0] into the destination register and drive mont_resetn=0.
REQ-014 SHALL implement states IDLE, TO_MONT, LOOP_SQ, LOOP_MUL, NEXT_BIT, FROM_MONT, DONE; each op state uses the ISSUE/WAIT/CAPTURE substates.
REQ-015 Transitions SHALL be: LOOP_SQ -> LOOP_MUL when e[i]=1, else LOOP_SQ -> NEXT_BIT; LOOP_MUL -> NEXT_BIT.
REQ-016 NEXT_BIT SHALL decrement i and go to LOOP_SQ, or go to FROM_MONT when i=0.
REQ-017 DONE SHALL last 1 cycle (done=1, busy=0), then go to IDLE.
REQ-018 result SHALL update only at FROM_MONT CAPTURE and hold until the next FROM_MONT CAPTURE.
REQ-019 The bit index SHALL be 10 bits wide and never underflow; elen=1 performs exactly one loop iteration.
REQ-020 e=0 SHALL give result=1 (for m>1) after 1+elen+1 ops.
REQ-021 mont_m SHALL equal the latched m throughout busy.
REQ-022 mont_resetn SHALL be 0 in IDLE and in every CAPTURE cycle, else 1.
REQ-023 mont_start SHALL be 0 outside ISSUE.
REQ-024 A mont_done=1 seen in ISSUE SHALL be ignored, since it is stale.

Reset
REQ-025 On resetn=0 at a clock edge, the block SHALL enter IDLE and drive busy=0, done=0, mont_start=0, mont_resetn=0, result=0, bit index=0.
REQ-026 Reset mid-operation SHALL abandon the operation without a done pulse; the next start SHALL behave as from power-up.

Configuration
REQ-027 Macro MODEXP_SKIP_LEADING_ZEROS_EN, defined: LOOP_SQ SHALL be skipped for every index i down to and including the highest set bit of e, because mont(R,R)=R makes those squarings identity; result SHALL be unchanged.
REQ-028 Macro undefined: every index SHALL perform LOOP_SQ; op count SHALL be 2+elen+popcount(e).

Verification
REQ-029 Bench SHALL use a behavioural 514-bit Montgomery model with done latency 600 cycles after mont_start, holding done until mont_resetn=0.
REQ-030 m=7, x=3, e=5, elen=3 -> result=5, done pulses once, busy low the cycle after done; 7 ops without macro.
REQ-031 e=0, elen=4, m=13, x=9 -> result=1; 6 ops in both configurations.
REQ-032 e=4'b0011, elen=4 -> 8 ops without macro, 5 ops with macro, identical result.
REQ-033 start re-asserted during WAIT -> ignored, latched operands unchanged, result correct.
REQ-034 resetn=0 during the third LOOP_SQ WAIT -> next cycle IDLE, mont_resetn=0, no done; a following start with x=2, e=10, elen=4, m=1000003 -> result=1024.
REQ-035 Random 512-bit odd m, x<m, e, elen=512 -> result matches reference modexp; mont_start is never high while mont_done=1 outside ISSUE.

Source files
------------

// File: rtl/mod_exp_ctrl.sv
// mod_exp_ctrl: controller for 512-bit modular exponentiation (x^e mod m).
// It sequences an external Montgomery multiplier using left-to-right binary
// exponentiation in the Montgomery domain:
//   xt = mont(x, R2); A = R mod m;
//   for i = elen-1 downto 0 { A = mont(A, A); if e[i] A = mont(A, xt) }
//   result = mont(A, 1)
// Every multiplier operation runs as ISSUE (1 cycle) -> WAIT (until mont_done) -> CAPTURE (1 cycle).
//
// Ports
//   clk, resetn        clock; synchronous active-low reset
//   start              begin an exponentiation (sampled only in IDLE)
//   busy, done         busy while working; done is a one-cycle completion pulse
//   in_x, in_e, in_m   base (< m), exponent, odd modulus
//   in_r, in_r2        R mod m and R^2 mod m, where R = 2^512
//   in_elen            exponent bit length 1..512 (0 means 512)
//   result             x^e mod m, updated only when the final conversion completes
//   mont_*             Montgomery multiplier handshake and operands; mont_done is a level
//                      that stays high until mont_resetn is driven low
//
// Configuration
//   MODEXP_SKIP_LEADING_ZEROS_EN  when defined, squarings are skipped for every index from the top
//                                 down to and including the highest set bit of e, because A is
//                                 still R there and mont(R, R) = R.
module mod_exp_ctrl (
   input  logic         clk,
   input  logic         resetn,
   input  logic         start,
   output logic         busy,
   output logic         done,
   input  logic [511:0] in_x,
   input  logic [511:0] in_e,
   input  logic [511:0] in_m,
   input  logic [511:0] in_r,
   input  logic [511:0] in_r2,
   input  logic [9:0]   in_elen,
   output logic [511:0] result,
   output logic         mont_resetn,
   output logic         mont_start,
   output logic [511:0] mont_a,
   output logic [511:0] mont_b,
   output logic [511:0] mont_m,
   input  logic [513:0] mont_result,
   input  logic         mont_done
);

`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
   localparam bit SkipLeadingZeros = 1'b1;
`else
   localparam bit SkipLeadingZeros = 1'b0;
`endif

   typedef enum logic [2:0] {
      StIdle,
      StToMont,
      StLoopSq,
      StLoopMul,
      StNextBit,
      StFromMont,
      StDone
   } state_e;

   typedef enum logic [1:0] {
      SubIssue,
      SubWait,
      SubCapture
   } sub_e;

   state_e       state_q, state_d;
   sub_e         sub_q, sub_d;
   logic [9:0]   idx_q, idx_d;
   logic [511:0] result_q, result_d;
   logic         lead_q, lead_d;   // still above the highest set bit of e (skip mode only)

   logic [511:0] x_q, e_q, m_q, r2_q;
   logic [511:0] a_q, a_d;
   logic [511:0] xt_q, xt_d;
   logic         load;

   logic [9:0]   elen_eff;
   logic [511:0] elen_mask;

   // Where processing of a bit index begins, for the index about to be entered.
   logic [9:0]   entry_idx;
   logic         entry_bit;
   state_e       entry_state;
   logic         entry_lead;

   // The multiplier returns up to 514 bits; only the reduced low 512 bits are consumed.
   logic         unused_mont_hi;
   assign unused_mont_hi = ^mont_result[513:512];

   always_comb begin
      elen_eff  = ((in_elen == 10'd0) || (in_elen > 10'd512)) ? 10'd512 : in_elen;
      elen_mask = {512{1'b1}} >> (10'd512 - elen_eff);
   end

   always_comb begin
      entry_idx   = (state_q == StNextBit) ? (idx_q - 10'd1) : idx_q;
      entry_bit   = e_q[entry_idx[8:0]];
      entry_state = StLoopSq;
      entry_lead  = lead_q;
      if (lead_q) begin
         // A is still R: squaring is an identity, so go straight to the multiply or the next bit.
         entry_state = entry_bit ? StLoopMul : StNextBit;
         entry_lead  = ~entry_bit;
      end
   end

   always_comb begin
      state_d     = state_q;
      sub_d       = sub_q;
      idx_d       = idx_q;
      result_d    = result_q;
      lead_d      = lead_q;
      a_d         = a_q;
      xt_d        = xt_q;
      load        = 1'b0;
      busy        = 1'b0;
      done        = 1'b0;
      mont_start  = 1'b0;
      mont_resetn = 1'b1;
      mont_a      = '0;
      mont_b      = '0;

      unique case (state_q)
         StIdle: begin
            mont_resetn = 1'b0;
            if (start) begin
               load    = 1'b1;
               idx_d   = elen_eff - 10'd1;
               a_d     = in_r;
               lead_d  = SkipLeadingZeros && (|(in_e & elen_mask));
               state_d = StToMont;
               sub_d   = SubIssue;
            end
         end

         StNextBit: begin
            busy  = 1'b1;
            sub_d = SubIssue;
            if (idx_q == 10'd0) begin
               state_d = StFromMont;
            end else begin
               idx_d   = entry_idx;
               state_d = entry_state;
               lead_d  = entry_lead;
            end
         end

         StDone: begin
            done    = 1'b1;
            state_d = StIdle;
         end

         default: begin
            // Multiplier operation states: TO_MONT, LOOP_SQ, LOOP_MUL, FROM_MONT.
            busy = 1'b1;
            unique case (state_q)
               StToMont: begin
                  mont_a = x_q;
                  mont_b = r2_q;
               end
               StLoopSq: begin
                  mont_a = a_q;
                  mont_b = a_q;
               end
               StLoopMul: begin
                  mont_a = a_q;
                  mont_b = xt_q;
               end
               default: begin
                  mont_a = a_q;
                  mont_b = 512'd1;
               end
            endcase

            unique case (sub_q)
               SubIssue: begin
                  // mont_done here would be stale from the previous op; never looked at.
                  mont_start = 1'b1;
                  sub_d      = SubWait;
               end
               SubWait: begin
                  if (mont_done) begin
                     sub_d = SubCapture;
                  end
               end
               SubCapture: begin
                  mont_resetn = 1'b0;
                  sub_d       = SubIssue;
                  unique case (state_q)
                     StToMont: begin
                        xt_d    = mont_result[511:0];
                        state_d = entry_state;
                        lead_d  = entry_lead;
                     end
                     StLoopSq: begin
                        a_d     = mont_result[511:0];
                        state_d = e_q[idx_q[8:0]] ? StLoopMul : StNextBit;
                     end
                     StLoopMul: begin
                        a_d     = mont_result[511:0];
                        state_d = StNextBit;
                     end
                     default: begin
                        result_d = mont_result[511:0];
                        state_d  = StDone;
                     end
                  endcase
               end
               default: begin
                  sub_d = SubIssue;
               end
            endcase
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_q  <= StIdle;
         sub_q    <= SubIssue;
         idx_q    <= '0;
         result_q <= '0;
         lead_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         sub_q    <= sub_d;
         idx_q    <= idx_d;
         result_q <= result_d;
         lead_q   <= lead_d;
      end
   end

   // Datapath registers; every operation reloads them on start, so no reset is needed.
   always_ff @(posedge clk) begin
      if (load) begin
         x_q  <= in_x;
         e_q  <= in_e;
         m_q  <= in_m;
         r2_q <= in_r2;
      end
      a_q  <= a_d;
      xt_q <= xt_d;
   end

   assign mont_m = m_q;
   assign result = result_q;

endmodule

// File: tb/tb_mod_exp_ctrl.sv
// Self-checking bench for mod_exp_ctrl with a behavioural Montgomery multiplier.
module tb_mod_exp_ctrl;

   logic         clk;
   logic         resetn;
   logic         start;
   logic         busy;
   logic         done;
   logic [511:0] in_x, in_e, in_m, in_r, in_r2;
   logic [9:0]   in_elen;
   logic [511:0] result;
   logic         mont_resetn, mont_start;
   logic [511:0] mont_a, mont_b, mont_m;
   logic [513:0] mont_result;
   logic         mont_done;

   int checks = 0;
   int errors = 0;

   int mont_lat = 600;
   int mcnt;
   logic mpend;
   int op_count = 0;
   int done_count = 0;
   int start_viol = 0;
   int m_viol = 0;
   logic [511:0] exp_m = '0;

   mod_exp_ctrl dut (
      .clk         (clk),
      .resetn      (resetn),
      .start       (start),
      .busy        (busy),
      .done        (done),
      .in_x        (in_x),
      .in_e        (in_e),
      .in_m        (in_m),
      .in_r        (in_r),
      .in_r2       (in_r2),
      .in_elen     (in_elen),
      .result      (result),
      .mont_resetn (mont_resetn),
      .mont_start  (mont_start),
      .mont_a      (mont_a),
      .mont_b      (mont_b),
      .mont_m      (mont_m),
      .mont_result (mont_result),
      .mont_done   (mont_done)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // ---------------- reference arithmetic ----------------
   function automatic logic [511:0] mont_f(input logic [511:0] a, input logic [511:0] b,
                                           input logic [511:0] m);
      logic [1025:0] t;
      t = {514'd0, a} * {514'd0, b};
      for (int i = 0; i < 512; i++) begin
         if (t[0]) t = t + {514'd0, m};
         t = t >> 1;
      end
      if (t >= {514'd0, m}) t = t - {514'd0, m};
      return t[511:0];
   endfunction

   function automatic logic [511:0] mulmod(input logic [511:0] a, input logic [511:0] b,
                                           input logic [511:0] m);
      logic [1023:0] p;
      p = {512'd0, a} * {512'd0, b};
      p = p % {512'd0, m};
      return p[511:0];
   endfunction

   function automatic logic [511:0] r_mod(input logic [511:0] m);
      logic [1023:0] r;
      r = 1024'd1 << 512;
      r = r % {512'd0, m};
      return r[511:0];
   endfunction

   function automatic int len_of(input logic [9:0] elen);
      return (elen == 10'd0) ? 512 : int'(elen);
   endfunction

   function automatic logic [511:0] ref_modexp(input logic [511:0] x, input logic [511:0] e,
                                               input logic [511:0] m, input int len);
      logic [511:0] acc;
      acc = (m == 512'd1) ? 512'd0 : 512'd1;
      for (int i = len - 1; i >= 0; i--) begin
         acc = mulmod(acc, acc, m);
         if (e[i]) acc = mulmod(acc, x, m);
      end
      return acc;
   endfunction

   function automatic int exp_ops(input logic [511:0] e, input int len);
      int pc;
      int top;
      pc  = 0;
      top = -1;
      for (int i = 0; i < len; i++) begin
         if (e[i]) begin
            pc++;
            top = i;
         end
      end
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
      if (top < 0) return 2 + len;
      return 2 + pc + top;
`else
      return 2 + len + pc;
`endif
   endfunction

   function automatic logic [511:0] rand512();
      logic [511:0] v;
      for (int i = 0; i < 16; i++) v[i*32 +: 32] = $urandom();
      return v;
   endfunction

   // ---------------- multiplier model and monitors ----------------
   always @(posedge clk) begin
      if (!mont_resetn) begin
         mont_done <= 1'b0;
         mpend     <= 1'b0;
      end else if (mont_start) begin
         mont_result <= {2'b00, mont_f(mont_a, mont_b, mont_m)};
         mpend       <= 1'b1;
         mcnt        <= mont_lat;
         mont_done   <= 1'b0;
      end else if (mpend) begin
         if (mcnt <= 1) begin
            mont_done <= 1'b1;
            mpend     <= 1'b0;
         end else begin
            mcnt <= mcnt - 1;
         end
      end
   end

   always @(posedge clk) begin
      if (mont_start) op_count <= op_count + 1;
   end

   always @(negedge clk) begin
      if (done) done_count++;
      if (mont_start && mont_done) start_viol++;
      if (busy && (mont_m !== exp_m)) m_viol++;
   end

   // ---------------- checking ----------------
   task automatic check_eq(input string tag, input logic [511:0] got, input logic [511:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [511:0] x, input logic [511:0] e,
                         input logic [511:0] m, input logic [9:0] elen, input int lat,
                         input bit poke, output logic [511:0] res, output int ops);
      int base;
      int dbase;
      int cyc;
      int budget;
      mont_lat = lat;
      budget   = 1100 * (lat + 4) + 100;
      exp_m    = m;
      in_x     = x;
      in_e     = e;
      in_m     = m;
      in_r     = r_mod(m);
      in_r2    = mulmod(in_r, in_r, m);
      in_elen  = elen;
      base     = op_count;
      dbase    = done_count;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      check_eq({tag, "_busy_after_start"}, busy, 1);
      cyc = 0;
      while (!done && cyc < budget) begin
         if (poke && cyc == 40) begin
            // Inside the first WAIT: a second start with different operands must be ignored.
            in_x    = ~x;
            in_e    = ~e;
            in_m    = m + 512'd2;
            in_r    = ~in_r;
            in_elen = elen + 10'd1;
            start   = 1'b1;
         end else begin
            start = 1'b0;
         end
         @(negedge clk);
         cyc++;
      end
      start = 1'b0;
      check_eq({tag, "_done_seen"}, done, 1);
      check_eq({tag, "_busy_at_done"}, busy, 0);
      res = result;
      ops = op_count - base;
      @(negedge clk);
      check_eq({tag, "_done_one_cycle"}, done, 0);
      check_eq({tag, "_busy_after_done"}, busy, 0);
      check_eq({tag, "_done_pulses"}, done_count - dbase, 1);
      check_eq({tag, "_result_held"}, result, res);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [511:0] res, x, e, m;
      logic [9:0]   elen;
      int ops, base, dbase, cyc;

      resetn  = 1'b0;
      start   = 1'b0;
      in_x    = '0;
      in_e    = '0;
      in_m    = '0;
      in_r    = '0;
      in_r2   = '0;
      in_elen = '0;
      repeat (3) @(negedge clk);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_done", done, 0);
      check_eq("rst_mont_start", mont_start, 0);
      check_eq("rst_mont_resetn", mont_resetn, 0);
      check_eq("rst_result", result, 0);
      resetn = 1'b1;
      @(negedge clk);
      check_eq("idle_mont_resetn", mont_resetn, 0);

      // 3^5 mod 7
      run_op("basic", 512'd3, 512'd5, 512'd7, 10'd3, 600, 1'b0, res, ops);
      check_eq("basic_result", res, 512'd5);
      check_eq("basic_ops", ops, exp_ops(512'd5, 3));

      // Zero exponent: no multiplies, no skipping possible.
      run_op("ezero", 512'd9, 512'd0, 512'd13, 10'd4, 600, 1'b0, res, ops);
      check_eq("ezero_result", res, 512'd1);
      check_eq("ezero_ops", ops, 6);

      // Leading zeros in the exponent window.
      run_op("lead", 512'd12345, 512'd3, 512'd1000003, 10'd4, 600, 1'b0, res, ops);
      check_eq("lead_result", res, ref_modexp(512'd12345, 512'd3, 512'd1000003, 4));
`ifdef MODEXP_SKIP_LEADING_ZEROS_EN
      check_eq("lead_ops", ops, 5);
`else
      check_eq("lead_ops", ops, 8);
`endif

      // Start re-asserted during WAIT with different operands.
      run_op("poke", 512'd3, 512'd5, 512'd7, 10'd3, 600, 1'b1, res, ops);
      check_eq("poke_result", res, 512'd5);
      check_eq("poke_ops", ops, exp_ops(512'd5, 3));

      // elen = 1 with exponent bits above the window that must be ignored.
      run_op("elen1", 512'd5, 512'd7, 512'd11, 10'd1, 20, 1'b0, res, ops);
      check_eq("elen1_result", res, 512'd5);
      check_eq("elen1_ops", ops, exp_ops(512'd7, 1));

      // Reset during the third squaring's WAIT (e=0: ops are TO_MONT, SQ, SQ, SQ, ...).
      mont_lat = 600;
      exp_m    = 512'd13;
      in_x     = 512'd9;
      in_e     = 512'd0;
      in_m     = 512'd13;
      in_r     = r_mod(512'd13);
      in_r2    = mulmod(in_r, in_r, 512'd13);
      in_elen  = 10'd4;
      base     = op_count;
      dbase    = done_count;
      start    = 1'b1;
      @(negedge clk);
      start = 1'b0;
      cyc   = 0;
      while ((op_count - base) < 4 && cyc < 10000) begin
         @(negedge clk);
         cyc++;
      end
      check_eq("rstmid_reached_sq3", op_count - base, 4);
      repeat (10) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      resetn = 1'b1;
      check_eq("rstmid_busy", busy, 0);
      check_eq("rstmid_mont_resetn", mont_resetn, 0);
      check_eq("rstmid_mont_start", mont_start, 0);
      repeat (5) @(negedge clk);
      check_eq("rstmid_no_done", done_count - dbase, 0);
      run_op("after_rst", 512'd2, 512'd10, 512'd1000003, 10'd4, 600, 1'b0, res, ops);
      check_eq("after_rst_result", res, 512'd1024);
      check_eq("after_rst_ops", ops, exp_ops(512'd10, 4));

      // Random 64-bit moduli with random short exponent lengths.
      for (int k = 0; k < 4; k++) begin
         m    = {448'd0, $urandom() | 32'h8000_0000, $urandom() | 32'd1};
         x    = {448'd0, $urandom(), $urandom()} % m;
         e    = rand512();
         elen = 10'($urandom_range(1, 64));
         run_op("rnd_small", x, e, m, elen, 8, 1'b0, res, ops);
         check_eq("rnd_small_result", res, ref_modexp(x, e, m, len_of(elen)));
         check_eq("rnd_small_ops", ops, exp_ops(e, len_of(elen)));
      end

      // Full-width random operands, elen = 512 given both explicitly and as 0.
      for (int k = 0; k < 2; k++) begin
         m    = rand512();
         m[511] = 1'b1;
         m[0]   = 1'b1;
         x    = rand512() % m;
         e    = rand512();
         elen = (k == 0) ? 10'd512 : 10'd0;
         run_op("rnd_full", x, e, m, elen, 8, 1'b0, res, ops);
         check_eq("rnd_full_result", res, ref_modexp(x, e, m, 512));
         check_eq("rnd_full_ops", ops, exp_ops(e, 512));
      end

      check_eq("start_while_done", start_viol, 0);
      check_eq("mont_m_stable", m_viol, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
